audio_dac_serializer: RTL and testbench

Output stage downstream of the echo/reverb block. Takes the processed 32-bit signed stereo pair (`out_L`/`out_R` of the effect chain) and serializes it onto the codec's I2S DAC data line. The codec is bus master and drives `AUD_BCLK`/`AUD_DACLRCK`; this block oversamples both in the `CLOCK_50` domain. Each stereo pair is latched coherently at the start of every left-channel frame, and the block pulses a one-cycle sample strobe.

---
 rtl/audio_dac_serializer.sv | 160 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: oversamples the codec's BCLK/LRCK in the CLOCK_50 domain and
// shifts a coherently latched stereo pair out MSB-first with the one-bit I2S delay.
module audio_dac_serializer #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_L,
  input  logic [WIDTH-1:0] in_R,
  input  logic             AUD_BCLK,
  input  logic             AUD_DACLRCK,
  output logic             AUD_DACDAT,
  output logic             sample_strobe,
  output logic             short_frame
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_ARM    = 3'd0,
    S_WAIT_L = 3'd1,
    S_DELAY  = 3'd2,
    S_SHIFT  = 3'd3,
    S_PAD    = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lrck_q, lrck_d;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [WIDTH-1:0]       hold_l_q, hold_l_d;
  logic [WIDTH-1:0]       hold_r_q, hold_r_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   dac_bit_q, dac_bit_d;
  logic                   dac_out_q, dac_out_d;
  logic                   strobe_q, strobe_d;
  logic                   short_q, short_d;

  logic          bclk_s, lrck_s, bclk_fall, boundary;
  logic [CW-1:0] bit_cnt_nxt;

  assign bclk_s      = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_fall   = bclk_prev_q & ~bclk_s;
  assign boundary    = lrck_s ^ lrck_q;
  assign bit_cnt_nxt = bit_cnt_q + CW'(1);

  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
    bclk_prev_d = bclk_s;
    lrck_d      = lrck_q;
    state_d     = state_q;
    shift_d     = shift_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    bit_cnt_d   = bit_cnt_q;
    dac_bit_d   = dac_bit_q;
    strobe_d    = 1'b0;
    short_d     = short_q;
    // Extra retiming stage so the pin changes a fixed SYNC_STAGES+2 cycles after BCLK falls.
    dac_out_d   = dac_bit_q;

    if (bclk_fall) begin
      lrck_d = lrck_s;
      case (state_q)
        S_ARM: begin
          dac_bit_d = 1'b0;
          state_d   = S_WAIT_L;
        end
        S_WAIT_L: begin
          dac_bit_d = 1'b0;
          if (boundary && !lrck_s) begin
            hold_l_d  = in_L;
            hold_r_d  = in_R;
            shift_d   = in_L;
            strobe_d  = 1'b1;
            bit_cnt_d = {CW{1'b0}};
            state_d   = S_DELAY;
          end else begin
            state_d = S_WAIT_L;
          end
        end
        S_DELAY, S_SHIFT, S_PAD: begin
          if (boundary) begin
            // The output keeps its last bit through the delay slot of the new word.
            if (state_q != S_PAD) begin
              short_d = 1'b1;
            end else begin
              short_d = short_q;
            end
            if (!lrck_s) begin
              hold_l_d = in_L;
              hold_r_d = in_R;
              shift_d  = in_L;
              strobe_d = 1'b1;
            end else begin
              shift_d = hold_r_q;
            end
            bit_cnt_d = {CW{1'b0}};
            state_d   = S_DELAY;
          end else if (state_q == S_PAD) begin
            dac_bit_d = 1'b0;
          end else begin
            dac_bit_d = shift_q[WIDTH-1];
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_nxt;
            state_d   = (bit_cnt_nxt == CW'(WIDTH)) ? S_PAD : S_SHIFT;
          end
        end
        default: begin
          dac_bit_d = 1'b0;
          state_d   = S_ARM;
        end
      endcase
    end else begin
      lrck_d = lrck_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_q <= {SYNC_STAGES{1'b0}};
      lrck_sync_q <= {SYNC_STAGES{1'b0}};
      bclk_prev_q <= 1'b0;
      lrck_q      <= 1'b0;
      state_q     <= S_ARM;
      shift_q     <= {WIDTH{1'b0}};
      hold_l_q    <= {WIDTH{1'b0}};
      hold_r_q    <= {WIDTH{1'b0}};
      bit_cnt_q   <= {CW{1'b0}};
      dac_bit_q   <= 1'b0;
      dac_out_q   <= 1'b0;
      strobe_q    <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_q      <= lrck_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      bit_cnt_q   <= bit_cnt_d;
      dac_bit_q   <= dac_bit_d;
      dac_out_q   <= dac_out_d;
      strobe_q    <= strobe_d;
      short_q     <= short_d;
    end
  end

  assign AUD_DACDAT    = dac_out_q;
  assign sample_strobe = strobe_q;
  assign short_frame   = short_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: two instances (SYNC_STAGES 2 and 3) driven by a
// codec-like BCLK/LRCK generator, checked bit by bit against a slot-position model.
module tb_audio_dac_serializer;

  localparam int W = 32;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_l, in_r;
  logic         bclk, lrck;
  logic         dat2, stb2, sf2;
  logic         dat3, stb3, sf3;

  always #10 clk = ~clk;

  audio_dac_serializer #(.WIDTH(W), .SYNC_STAGES(2)) dut2 (
    .CLOCK_50(clk), .reset(reset), .in_L(in_l), .in_R(in_r),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck),
    .AUD_DACDAT(dat2), .sample_strobe(stb2), .short_frame(sf2)
  );

  audio_dac_serializer #(.WIDTH(W), .SYNC_STAGES(3)) dut3 (
    .CLOCK_50(clk), .reset(reset), .in_L(in_l), .in_R(in_r),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck),
    .AUD_DACDAT(dat3), .sample_strobe(stb3), .short_frame(sf3)
  );

  int compared   = 0;
  int mismatched = 0;
  int stb_cnt2   = 0;
  int stb_cnt3   = 0;

  always @(posedge clk) begin
    if (stb2) stb_cnt2 <= stb_cnt2 + 1;
    if (stb3) stb_cnt3 <= stb_cnt3 + 1;
  end

  // Reference model: tracks position within the current channel slot.
  logic         m_seen_fall, m_locked, m_prev_lrck, m_out, m_short;
  logic [W-1:0] m_word, m_pair_r;
  int           m_pos, m_strobes;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           nl;
    int           nr;
    logic         exp_short;
  } vec_t;

  vec_t vecs[5];

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seen_fall = 1'b0;
    m_locked    = 1'b0;
    m_prev_lrck = 1'b0;
    m_out       = 1'b0;
    m_short     = 1'b0;
    m_word      = '0;
    m_pair_r    = '0;
    m_pos       = 0;
  endtask

  task automatic model_start_left();
    m_word   = in_l;
    m_pair_r = in_r;
    m_pos    = 0;
    m_strobes++;
  endtask

  task automatic model_fall(input logic new_lrck);
    logic bnd;
    bnd = (new_lrck != m_prev_lrck);
    if (!m_seen_fall) begin
      m_seen_fall = 1'b1;
      m_out       = 1'b0;
    end else if (!m_locked) begin
      m_out = 1'b0;
      if (bnd && !new_lrck) begin
        m_locked = 1'b1;
        model_start_left();
      end
    end else if (bnd) begin
      if (m_pos < W) m_short = 1'b1;
      if (!new_lrck) begin
        model_start_left();
      end else begin
        m_word = m_pair_r;
        m_pos  = 0;
      end
    end else begin
      m_pos++;
      m_out = (m_pos <= W) ? m_word[W - m_pos] : 1'b0;
    end
    m_prev_lrck = new_lrck;
  endtask

  // One BCLK period starting with a falling edge; checks latency and steady values.
  task automatic drive_bit(input logic lv);
    logic prev_exp, old2, old3;
    int   lat2, lat3;
    prev_exp = m_out;
    old2     = dat2;
    old3     = dat3;
    lat2     = -1;
    lat3     = -1;
    bclk     = 1'b0;
    lrck     = lv;
    model_fall(lv);
    for (int k = 1; k <= 2 * H; k++) begin
      @(negedge clk);
      if (lat2 < 0 && dat2 !== old2) lat2 = k;
      if (lat3 < 0 && dat3 !== old3) lat3 = k;
      if (k == H) bclk = 1'b1;
    end
    if (m_out != prev_exp) begin
      check_int("latency_sync2", lat2, 4);
      check_int("latency_sync3", lat3, 5);
    end
    check_bit("dacdat_sync2", dat2, m_out);
    check_bit("dacdat_sync3", dat3, m_out);
    check_bit("short_sync2", sf2, m_short);
    check_bit("short_sync3", sf3, m_short);
  endtask

  task automatic send_slot(input logic lv, input int n);
    for (int i = 0; i < n; i++) drive_bit(lv);
  endtask

  task automatic check_strobes();
    check_int("strobe_count_sync2", stb_cnt2, m_strobes);
    check_int("strobe_count_sync3", stb_cnt3, m_strobes);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int nl, input int nr);
    in_l = l;
    in_r = r;
    send_slot(1'b0, nl);
    send_slot(1'b1, nr);
    check_strobes();
  endtask

  initial begin
    vecs[0] = '{32'h8000_0001, 32'h7FFF_FFFF, 64, 64, 1'b0};
    vecs[1] = '{32'h1234_5678, 32'h8765_4321, 40, 36, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 33, 33, 1'b0};
    vecs[3] = '{32'hA5A5_5A5A, 32'h0F0F_F0F0, 24, 24, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 64, 64, 1'b1};

    m_strobes = 0;
    model_reset();
    reset = 1'b1;
    bclk  = 1'b1;
    lrck  = 1'b1;
    in_l  = '0;
    in_r  = '0;
    repeat (4) @(negedge clk);
    check_bit("reset_dacdat_sync2", dat2, 1'b0);
    check_bit("reset_dacdat_sync3", dat3, 1'b0);
    check_bit("reset_strobe", stb2, 1'b0);
    check_bit("reset_short_sync2", sf2, 1'b0);
    check_bit("reset_short_sync3", sf3, 1'b0);
    reset = 1'b0;
    repeat (H) @(negedge clk);

    // Released during a right slot: nothing goes out until the next left frame.
    in_l = 32'hFFFF_FFFF;
    in_r = 32'hFFFF_FFFF;
    send_slot(1'b1, 20);
    check_int("no_strobe_before_left", stb_cnt2, 0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].l, vecs[i].r, vecs[i].nl, vecs[i].nr);
      check_bit("table_short", sf2, vecs[i].exp_short);
    end

    // in_R changes mid-left-slot: right slot still carries the latched pair.
    in_l = 32'h8000_0001;
    in_r = 32'h7FFF_FFFF;
    send_slot(1'b0, 20);
    in_r = 32'h0000_0000;
    send_slot(1'b0, 44);
    send_slot(1'b1, 64);
    send_frame(32'h0000_00FF, 32'h0000_0000, 64, 64);

    // One-cycle reset at bit 10 of a left slot.
    in_l = 32'hFFFF_FFFF;
    in_r = 32'h5555_AAAA;
    send_slot(1'b0, 11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("midreset_dacdat_sync2", dat2, 1'b0);
    check_bit("midreset_dacdat_sync3", dat3, 1'b0);
    check_bit("midreset_short_sync2", sf2, 1'b0);
    check_bit("midreset_short_sync3", sf3, 1'b0);
    model_reset();
    repeat (H) @(negedge clk);
    send_slot(1'b0, 53);
    send_slot(1'b1, 64);
    check_strobes();
    send_frame(32'hC000_0003, 32'h3FFF_FFFC, 64, 64);
    check_bit("after_reset_short", sf2, 1'b0);

    for (int f = 0; f < 20; f++) begin
      send_frame($urandom, $urandom, $urandom_range(20, 48), $urandom_range(20, 48));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
